// File: rtl/bin_arbiter_if.sv
// Operand/grant/result bundle between the kernel FSMs (master) and the shared-adder arbiter (slave).
interface bin_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 64
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] in0;
  logic [NREQ*WIDTH-1:0] in1;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [WIDTH-1:0]      result;
  logic                  carry;

  modport master (output req, in0, in1, input gnt, rvalid, result, carry);
  modport slave  (input req, in0, in1, output gnt, rvalid, result, carry);
endinterface

// File: rtl/bin_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters.
// Define BIN_ARB_PIPE_EN to add a result register stage (rvalid/result one cycle after gnt).
module bin_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 64
) (
  input logic           clk,
  input logic           r_enable,
  bin_arbiter_if.slave  bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PW-1:0] idx_t;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  idx_t             ptr_q, ptr_d;
  logic [WIDTH:0]   res_q, res_d;
  idx_t             win;
  logic             found;
  logic [PW:0]      cand;
  logic [WIDTH-1:0] opa, opb;

  // Search ptr, ptr+1, ... wrapping at NREQ; first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && bus.req[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    opa = bus.in0[win*WIDTH +: WIDTH];
    opb = bus.in1[win*WIDTH +: WIDTH];
  end

  always_comb begin
    gnt_d = '0;
    ptr_d = ptr_q;
    res_d = res_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      ptr_d      = (win == idx_t'(NREQ-1)) ? '0 : win + 1'b1;
      res_d      = {1'b0, opa} + {1'b0, opb};
    end
  end

  always_ff @(posedge clk) begin
    if (r_enable) begin
      gnt_q <= '0;
      ptr_q <= '0;
      res_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      res_q <= res_d;
    end
  end

  assign bus.gnt = gnt_q;

`ifdef BIN_ARB_PIPE_EN
  logic [NREQ-1:0] tag_q;
  logic [WIDTH:0]  out_q;

  // Second stage follows the first every cycle, so hold behaviour carries through.
  always_ff @(posedge clk) begin
    if (r_enable) begin
      tag_q <= '0;
      out_q <= '0;
    end else begin
      tag_q <= gnt_q;
      out_q <= res_q;
    end
  end

  assign bus.rvalid = tag_q;
  assign bus.carry  = out_q[WIDTH];
  assign bus.result = out_q[WIDTH-1:0];
`else
  assign bus.rvalid = gnt_q;
  assign bus.carry  = res_q[WIDTH];
  assign bus.result = res_q[WIDTH-1:0];
`endif
endmodule
